branch_redirect: RTL and testbench

- ID-stage branch/jump resolution unit, directly downstream of the ID-stage equality/sign comparator.
- Consumes the comparator's taken bit plus decoded instruction fields, and computes the redirect target and link information.
- Holds the redirect until the PC register accepts it, and tracks the branch-delay-slot flag for the instruction that follows.
- Outputs feed the PC mux, the stall/hazard unit, and the ID/EX pipeline register.

---
 rtl/branch_redirect_pkg.sv | 32 +++
 rtl/branch_target_calc.sv | 74 +++++++
 rtl/branch_redirect.sv | 99 +++++++++
 tb/tb_branch_redirect.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_redirect_pkg.sv
// rtl/branch_redirect_pkg.sv - MIPS32 branch/jump encodings and shared types for ID-stage redirect
package branch_redirect_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  localparam logic [5:0] FUNCT_JR   = 6'b001000;
  localparam logic [5:0] FUNCT_JALR = 6'b001001;

  localparam logic [4:0] RT_BLTZ    = 5'b00000;
  localparam logic [4:0] RT_BGEZ    = 5'b00001;
  localparam logic [4:0] RT_BLTZAL  = 5'b10000;
  localparam logic [4:0] RT_BGEZAL  = 5'b10001;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic {ST_IDLE, ST_PEND} redirect_state_e;

  // BR_COND follows the comparator; the other kinds are unconditionally taken.
  typedef enum logic [1:0] {BR_NONE, BR_COND, BR_JUMP, BR_REG} br_kind_e;

  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// rtl/branch_target_calc.sv - combinational branch/jump decode, target and link computation
module branch_target_calc
  import branch_redirect_pkg::*;
#(
  parameter int         ADDR_W   = 32,
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic [5:0]        op,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm16,
  input  logic [25:0]       instr_index,
  input  logic [ADDR_W-1:0] rs_val,
  input  logic [ADDR_W-1:0] pc_plus4,
  output br_kind_e          kind,
  output logic [ADDR_W-1:0] target,
  output logic              link_en,
  output logic [4:0]        link_reg,
  output logic [ADDR_W-1:0] link_addr
);

  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] j_target;

  assign br_target = pc_plus4 + ADDR_W'(branch_offset(imm16));
  assign j_target  = {pc_plus4[ADDR_W-1:28], instr_index, 2'b00};
  assign link_addr = pc_plus4 + ADDR_W'(4);

  always_comb begin
    kind     = BR_NONE;
    target   = br_target;
    link_en  = 1'b0;
    link_reg = 5'd0;
    case (op)
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: kind = BR_COND;
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ: kind = BR_COND;
          // The -AL forms write the link register whether or not they are taken.
          RT_BLTZAL, RT_BGEZAL: begin
            kind     = BR_COND;
            link_en  = 1'b1;
            link_reg = LINK_REG;
          end
          default: ;
        endcase
      end
      OP_J: begin
        kind   = BR_JUMP;
        target = j_target;
      end
      OP_JAL: begin
        kind     = BR_JUMP;
        target   = j_target;
        link_en  = 1'b1;
        link_reg = LINK_REG;
      end
      OP_SPECIAL: begin
        if (funct == FUNCT_JR) begin
          kind   = BR_REG;
          target = rs_val;
        end else if (funct == FUNCT_JALR) begin
          kind     = BR_REG;
          target   = rs_val;
          link_en  = 1'b1;
          link_reg = rd;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_redirect.sv
// rtl/branch_redirect.sv - ID-stage branch resolution: redirect hold FSM and delay-slot tracking
module branch_redirect
  import branch_redirect_pkg::*;
#(
  parameter int         ADDR_W   = 32,
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              id_valid,
  input  logic              id_advance,
  input  logic              flush,
  input  logic [5:0]        op,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm16,
  input  logic [25:0]       instr_index,
  input  logic              cmp_taken,
  input  logic [ADDR_W-1:0] rs_val,
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic              pc_ready,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              busy,
  output logic              link_en,
  output logic [4:0]        link_reg,
  output logic [ADDR_W-1:0] link_addr,
  output logic              is_branch,
  output logic              in_delayslot
);

  br_kind_e          kind;
  logic [ADDR_W-1:0] target;
  logic              dec_link_en;
  logic [4:0]        dec_link_reg;

  redirect_state_e   state;
  logic [ADDR_W-1:0] pend_pc;
  logic              ds_next;
  logic              decoded;
  logic              taken;

  branch_target_calc #(
    .ADDR_W   (ADDR_W),
    .LINK_REG (LINK_REG)
  ) u_calc (
    .op          (op),
    .rt          (rt),
    .rd          (rd),
    .funct       (funct),
    .imm16       (imm16),
    .instr_index (instr_index),
    .rs_val      (rs_val),
    .pc_plus4    (pc_plus4),
    .kind        (kind),
    .target      (target),
    .link_en     (dec_link_en),
    .link_reg    (dec_link_reg),
    .link_addr   (link_addr)
  );

  assign decoded = id_valid && (kind != BR_NONE);
  assign taken   = decoded && ((kind == BR_COND) ? cmp_taken : 1'b1);

  // Decode-derived outputs are masked by resetn so that reset silences them without a clock.
  assign is_branch      = resetn && decoded;
  assign link_en        = resetn && id_valid && dec_link_en;
  assign link_reg       = link_en ? dec_link_reg : 5'd0;
  assign redirect_valid = resetn && !flush && ((state == ST_PEND) || taken);
  assign redirect_pc    = (state == ST_PEND) ? pend_pc : target;
  assign busy           = (state == ST_PEND);
  assign in_delayslot   = ds_next && id_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      pend_pc <= ADDR_W'(ZERO_WORD);
      ds_next <= 1'b0;
    end else if (flush) begin
      state   <= ST_IDLE;
      pend_pc <= ADDR_W'(ZERO_WORD);
      ds_next <= 1'b0;
    end else begin
      if (state == ST_IDLE) begin
        if (taken && !pc_ready) begin
          state   <= ST_PEND;
          pend_pc <= target;
        end
      end else if (pc_ready) begin
        state <= ST_IDLE;
      end
      if (id_advance) begin
        ds_next <= decoded;
      end
    end
  end

endmodule

// File: tb/tb_branch_redirect.sv
// tb/tb_branch_redirect.sv - scoreboard bench for branch_redirect with directed vectors
module tb_branch_redirect;

  localparam logic [5:0] E_SPECIAL = 6'b000000;
  localparam logic [5:0] E_REGIMM  = 6'b000001;
  localparam logic [5:0] E_J       = 6'b000010;
  localparam logic [5:0] E_JAL     = 6'b000011;
  localparam logic [5:0] E_BEQ     = 6'b000100;
  localparam logic [5:0] E_BNE     = 6'b000101;
  localparam logic [5:0] E_ADD_FN  = 6'b100000;
  localparam logic [5:0] E_JALR_FN = 6'b001001;
  localparam logic [4:0] E_BLTZAL  = 5'b10000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        id_valid, id_advance, flush;
  logic [5:0]  op;
  logic [4:0]  rt, rd;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic        cmp_taken;
  logic [31:0] rs_val, pc_plus4;
  logic        pc_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy, link_en;
  logic [4:0]  link_reg;
  logic [31:0] link_addr;
  logic        is_branch, in_delayslot;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic        rv;
    logic        chk_pc;
    logic [31:0] rpc;
    logic        busy;
    logic        len;
    logic [4:0]  lreg;
    logic [31:0] laddr;
    logic        isb;
    logic        ds;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;

  branch_redirect #(.ADDR_W(32), .LINK_REG(5'd31)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .id_valid       (id_valid),
    .id_advance     (id_advance),
    .flush          (flush),
    .op             (op),
    .rt             (rt),
    .rd             (rd),
    .funct          (funct),
    .imm16          (imm16),
    .instr_index    (instr_index),
    .cmp_taken      (cmp_taken),
    .rs_val         (rs_val),
    .pc_plus4       (pc_plus4),
    .pc_ready       (pc_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy),
    .link_en        (link_en),
    .link_reg       (link_reg),
    .link_addr      (link_addr),
    .is_branch      (is_branch),
    .in_delayslot   (in_delayslot)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string n, input string f, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s.%s: got %h expected %h", n, f, act, want);
    end
  endtask

  // Monitor: pops every expectation the stimulus posts and compares against live outputs.
  always begin
    @(sample_ev);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp(e.name, "redirect_valid", {31'd0, redirect_valid}, {31'd0, e.rv});
      if (e.chk_pc) cmp(e.name, "redirect_pc", redirect_pc, e.rpc);
      cmp(e.name, "busy", {31'd0, busy}, {31'd0, e.busy});
      cmp(e.name, "link_en", {31'd0, link_en}, {31'd0, e.len});
      cmp(e.name, "link_reg", {27'd0, link_reg}, {27'd0, e.lreg});
      cmp(e.name, "link_addr", link_addr, e.laddr);
      cmp(e.name, "is_branch", {31'd0, is_branch}, {31'd0, e.isb});
      cmp(e.name, "in_delayslot", {31'd0, in_delayslot}, {31'd0, e.ds});
    end
  end

  function automatic exp_t mk(input string n, input logic rv, input logic cpc, input logic [31:0] rpc,
                              input logic b, input logic len, input logic [4:0] lreg,
                              input logic [31:0] laddr, input logic isb, input logic ds);
    exp_t e;
    e.name = n; e.rv = rv; e.chk_pc = cpc; e.rpc = rpc; e.busy = b;
    e.len = len; e.lreg = lreg; e.laddr = laddr; e.isb = isb; e.ds = ds;
    return e;
  endfunction

  task automatic post(input exp_t e);
    exp_q.push_back(e);
    -> sample_ev;
    #0;
  endtask

  // Inputs are applied at posedge+1; expectations are checked at the following negedge.
  task automatic step(input exp_t e);
    #4;
    post(e);
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [5:0] o, input logic [4:0] t, input logic [4:0] d,
                       input logic [5:0] f, input logic [15:0] im, input logic [25:0] idx);
    op = o; rt = t; rd = d; funct = f; imm16 = im; instr_index = idx;
  endtask

  task automatic add_instr();
    instr(E_SPECIAL, 5'd2, 5'd3, E_ADD_FN, 16'h1820, 26'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; id_valid = 1'b0; id_advance = 1'b0; flush = 1'b0;
    cmp_taken = 1'b0; rs_val = 32'h0; pc_plus4 = 32'h0; pc_ready = 1'b0;
    instr(6'h0, 5'h0, 5'h0, 6'h0, 16'h0, 26'h0);
    @(posedge clk); #1;
    step(mk("reset", 0, 0, 32'h0, 0, 0, 5'd0, 32'h4, 0, 0));
    resetn = 1'b1;

    instr(E_BEQ, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0);
    id_valid = 1; id_advance = 1; cmp_taken = 1; pc_ready = 1; pc_plus4 = 32'h0040_0004;
    step(mk("beq_taken", 1, 1, 32'h0040_0000, 0, 0, 5'd0, 32'h0040_0008, 1, 0));

    add_instr(); cmp_taken = 0; pc_plus4 = 32'h0040_0008;
    step(mk("beq_slot", 0, 0, 32'h0, 0, 0, 5'd0, 32'h0040_000C, 0, 1));

    instr(E_JAL, 5'd0, 5'd0, 6'h0, 16'h0, 26'h000_0040);
    id_advance = 0; pc_ready = 0; pc_plus4 = 32'hBFC0_0010;
    step(mk("jal_req", 1, 1, 32'hB000_0100, 0, 1, 5'd31, 32'hBFC0_0014, 1, 0));
    instr_index = 26'h3FF_FFFF;
    step(mk("jal_hold1", 1, 1, 32'hB000_0100, 1, 1, 5'd31, 32'hBFC0_0014, 1, 0));
    step(mk("jal_hold2", 1, 1, 32'hB000_0100, 1, 1, 5'd31, 32'hBFC0_0014, 1, 0));
    pc_ready = 1; id_advance = 1;
    step(mk("jal_accept", 1, 1, 32'hB000_0100, 1, 1, 5'd31, 32'hBFC0_0014, 1, 0));

    add_instr(); pc_plus4 = 32'hB000_0104;
    step(mk("jal_slot", 0, 0, 32'h0, 0, 0, 5'd0, 32'hB000_0108, 0, 1));

    instr(E_REGIMM, E_BLTZAL, 5'd0, 6'h0, 16'h0010, 26'h0);
    cmp_taken = 0; id_advance = 0; pc_plus4 = 32'h0000_1000;
    step(mk("bltzal_nt", 0, 0, 32'h0, 0, 1, 5'd31, 32'h0000_1004, 1, 0));

    instr(E_SPECIAL, 5'd0, 5'd5, E_JALR_FN, 16'h2809, 26'h0);
    rs_val = 32'h8000_1234; pc_ready = 1; id_advance = 1; pc_plus4 = 32'h0000_2000;
    step(mk("jalr", 1, 1, 32'h8000_1234, 0, 1, 5'd5, 32'h0000_2004, 1, 0));
    add_instr(); pc_plus4 = 32'h0000_2004;
    step(mk("jalr_slot", 0, 0, 32'h0, 0, 0, 5'd0, 32'h0000_2008, 0, 1));
    pc_plus4 = 32'h0000_2008;
    step(mk("after_slot", 0, 0, 32'h0, 0, 0, 5'd0, 32'h0000_200C, 0, 0));

    instr(E_BNE, 5'd1, 5'd0, 6'h0, 16'h0010, 26'h0);
    cmp_taken = 1; pc_ready = 0; id_advance = 1; pc_plus4 = 32'h0000_0100;
    step(mk("bne_req", 1, 1, 32'h0000_0140, 0, 0, 5'd0, 32'h0000_0104, 1, 0));
    add_instr(); cmp_taken = 0; flush = 1; pc_ready = 1; id_advance = 0; pc_plus4 = 32'h0000_0104;
    step(mk("flush_pend", 0, 0, 32'h0, 1, 0, 5'd0, 32'h0000_0108, 0, 1));
    flush = 0; pc_ready = 0;
    step(mk("post_flush", 0, 0, 32'h0, 0, 0, 5'd0, 32'h0000_0108, 0, 0));

    instr(E_J, 5'd0, 5'd0, 6'h0, 16'h0, 26'h000_0001);
    id_advance = 1; pc_plus4 = 32'h1000_0000;
    step(mk("j_req", 1, 1, 32'h1000_0004, 0, 0, 5'd0, 32'h1000_0004, 1, 0));
    add_instr(); id_advance = 0; pc_plus4 = 32'h1000_0004;
    #4;
    post(mk("j_pend", 1, 1, 32'h1000_0004, 1, 0, 5'd0, 32'h1000_0008, 0, 1));
    #1 resetn = 1'b0;
    #1;
    post(mk("async_rst", 0, 0, 32'h0, 0, 0, 5'd0, 32'h1000_0008, 0, 0));
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    step(mk("post_rst", 0, 0, 32'h0, 0, 0, 5'd0, 32'h1000_0008, 0, 0));

    instr(E_BEQ, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0);
    cmp_taken = 0; pc_plus4 = 32'h0000_3000;
    step(mk("beq_nt", 0, 0, 32'h0, 0, 0, 5'd0, 32'h0000_3004, 1, 0));
    step(mk("beq_nt_idle", 0, 0, 32'h0, 0, 0, 5'd0, 32'h0000_3004, 1, 0));

    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
